// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with standard or first-word-fall-through read
//
// Ports:
//   sys_clk, sys_rst   rising-edge clock, asynchronous active-high reset
//   clr                synchronous flush (pointers, count, error pulses, read data)
//   wr_en, wr_data     write request and data
//   rd_en              read request (pop of the displayed word in FWFT mode)
//   rd_data, rd_valid  read data and its qualifier
//   full, empty        count == DEPTH / count == 0
//   almost_full        count >= AFULL_TH
//   almost_empty       count <= AEMPTY_TH
//   count              stored words, 0..DEPTH
//   overflow           one-cycle pulse after a rejected write
//   underflow          one-cycle pulse after a rejected read
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = (2 ** ADDR_W) - 4,
    parameter int AEMPTY_TH = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int              DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W + 1)'(AFULL_TH);
    localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W + 1)'(AEMPTY_TH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic              overflow_q;
    logic              underflow_q;
    logic              wr_accept;
    logic              rd_accept;

    // Flags decode the registered count, so they settle on the same edge as count.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AFULL_C);
    assign almost_empty = (count_q <= AEMPTY_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Acceptance uses the pre-edge flags: at full a read still frees a slot
    // only for the next cycle, so a simultaneous write is rejected.
    assign wr_accept = wr_en && !full && !clr;
    assign rd_accept = rd_en && !empty && !clr;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (clr) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({wr_accept, rd_accept})
                2'b10:   count_q <= count_q + (ADDR_W + 1)'(1);
                2'b01:   count_q <= count_q - (ADDR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
            overflow_q  <= wr_en && full;
            underflow_q <= rd_en && empty;
        end
    end

    // Storage is intentionally not reset; zeroed pointers make old contents unreachable.
    always_ff @(posedge sys_clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head of queue is always on the output; rd_en just advances rd_ptr.
            assign rd_data  = mem[rd_ptr];
            assign rd_valid = !empty;
        end else begin : g_std
            logic [DATA_W-1:0] rd_data_q;
            logic              rd_valid_q;

            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else if (clr) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_accept;
                    if (rd_accept) begin
                        rd_data_q <= mem[rd_ptr];
                    end
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - directed bench driving standard and FWFT instances in lockstep
module tb_sync_fifo_param;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       clr     = 1'b0;
    logic       wr_en   = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_en   = 1'b0;

    logic [7:0] s_rd_data, f_rd_data;
    logic       s_rd_valid, f_rd_valid;
    logic       s_full, f_full, s_empty, f_empty;
    logic       s_afull, f_afull, s_aempty, f_aempty;
    logic [4:0] s_count, f_count;
    logic       s_ovf, f_ovf, s_unf, f_unf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 sys_clk = ~sys_clk;

    sync_fifo_param #(.DATA_W(8), .ADDR_W(4), .FWFT(0), .AFULL_TH(12), .AEMPTY_TH(3)) u_std (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .clr(clr),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(s_rd_data), .rd_valid(s_rd_valid),
        .full(s_full), .empty(s_empty), .almost_full(s_afull), .almost_empty(s_aempty),
        .count(s_count), .overflow(s_ovf), .underflow(s_unf)
    );

    sync_fifo_param #(.DATA_W(8), .ADDR_W(4), .FWFT(1), .AFULL_TH(12), .AEMPTY_TH(3)) u_fwft (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .clr(clr),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid),
        .full(f_full), .empty(f_empty), .almost_full(f_afull), .almost_empty(f_aempty),
        .count(f_count), .overflow(f_ovf), .underflow(f_unf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk_level(input string tag, input int n);
        chk({tag, " s_count"},  s_count,  n);
        chk({tag, " f_count"},  f_count,  n);
        chk({tag, " s_empty"},  s_empty,  (n == 0));
        chk({tag, " f_empty"},  f_empty,  (n == 0));
        chk({tag, " s_full"},   s_full,   (n == 16));
        chk({tag, " f_full"},   f_full,   (n == 16));
        chk({tag, " s_afull"},  s_afull,  (n >= 12));
        chk({tag, " f_afull"},  f_afull,  (n >= 12));
        chk({tag, " s_aempty"}, s_aempty, (n <= 3));
        chk({tag, " f_aempty"}, f_aempty, (n <= 3));
    endtask

    task automatic chk_err(input string tag, input logic ovf, input logic unf);
        chk({tag, " s_ovf"}, s_ovf, ovf);
        chk({tag, " f_ovf"}, f_ovf, ovf);
        chk({tag, " s_unf"}, s_unf, unf);
        chk({tag, " f_unf"}, f_unf, unf);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk_level("rst", 0);
        chk_err("rst", 1'b0, 1'b0);
        chk("rst s_rd_data", s_rd_data, 8'h00);
        chk("rst s_rd_valid", s_rd_valid, 1'b0);
        chk("rst f_rd_valid", f_rd_valid, 1'b0);
        sys_rst = 1'b0;

        // Fill 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(i);
            tick();
            chk_level("fill", i + 1);
            chk("fill f_rd_valid", f_rd_valid, 1'b1);
            chk("fill f_rd_data", f_rd_data, 8'h00);
        end

        // Overflow at full: 0xAA must be dropped
        wr_data = 8'hAA;
        tick();
        chk_level("ovf", 16);
        chk_err("ovf", 1'b1, 1'b0);
        wr_en = 1'b0;
        tick();
        chk_err("ovf idle", 1'b0, 1'b0);

        // Drain: FWFT shows the word before the pop, standard returns it after
        for (int i = 0; i < 16; i++) begin
            chk("drain f_rd_data", f_rd_data, 8'(i));
            rd_en = 1'b1;
            tick();
            chk("drain s_rd_data", s_rd_data, 8'(i));
            chk("drain s_rd_valid", s_rd_valid, 1'b1);
            chk_level("drain", 15 - i);
        end
        rd_en = 1'b0;
        tick();
        chk("hold s_rd_valid", s_rd_valid, 1'b0);
        chk("hold s_rd_data", s_rd_data, 8'h0F);
        chk("hold f_rd_valid", f_rd_valid, 1'b0);
        chk_err("drain idle", 1'b0, 1'b0);

        // Underflow when empty
        rd_en = 1'b1;
        tick();
        chk_level("unf", 0);
        chk_err("unf", 1'b0, 1'b1);
        chk("unf s_rd_valid", s_rd_valid, 1'b0);
        rd_en = 1'b0;
        tick();
        chk_err("unf idle", 1'b0, 1'b0);

        // Write+read when empty: write wins, FWFT shows 0x5C at once
        wr_en = 1'b1;
        rd_en = 1'b1;
        wr_data = 8'h5C;
        tick();
        chk_level("wr_rd empty", 1);
        chk_err("wr_rd empty", 1'b0, 1'b1);
        chk("fwft lat data", f_rd_data, 8'h5C);
        chk("fwft lat valid", f_rd_valid, 1'b1);
        wr_en = 1'b0;
        rd_en = 1'b0;
        tick();
        chk_err("wr_rd empty idle", 1'b0, 1'b0);

        // Standard latency: data and valid right after the accepting edge
        rd_en = 1'b1;
        tick();
        chk("std lat data", s_rd_data, 8'h5C);
        chk("std lat valid", s_rd_valid, 1'b1);
        chk_level("std lat", 0);
        rd_en = 1'b0;

        // Wrap-around with 4 resident words
        for (int k = 0; k < 4; k++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'h10 + k);
            tick();
        end
        chk_level("preload", 4);
        for (int k = 0; k < 40; k++) begin
            chk("wrap f_rd_data", f_rd_data, 8'(8'h10 + k));
            wr_en = 1'b1;
            rd_en = 1'b1;
            wr_data = 8'(8'h14 + k);
            tick();
            chk("wrap s_count", s_count, 5'd4);
            chk("wrap f_count", f_count, 5'd4);
            chk("wrap s_rd_data", s_rd_data, 8'(8'h10 + k));
            chk("wrap s_rd_valid", s_rd_valid, 1'b1);
            chk_err("wrap", 1'b0, 1'b0);
        end
        rd_en = 1'b0;

        // Refill to full, then write+read at full
        for (int k = 0; k < 12; k++) begin
            wr_data = 8'(8'h3C + k);
            tick();
        end
        chk_level("refill", 16);
        rd_en = 1'b1;
        wr_data = 8'hBB;
        tick();
        chk_level("wr_rd full", 15);
        chk_err("wr_rd full", 1'b1, 1'b0);
        chk("wr_rd full s_rd_data", s_rd_data, 8'h38);
        wr_en = 1'b0;
        rd_en = 1'b0;
        tick();
        chk_err("wr_rd full idle", 1'b0, 1'b0);

        // Read down to 9 words
        for (int k = 0; k < 6; k++) begin
            rd_en = 1'b1;
            tick();
            chk("to9 s_rd_data", s_rd_data, 8'(8'h39 + k));
        end
        rd_en = 1'b0;
        chk_level("nine", 9);

        // Flush with concurrent requests
        clr = 1'b1;
        wr_en = 1'b1;
        rd_en = 1'b1;
        wr_data = 8'h77;
        tick();
        chk_level("clr", 0);
        chk_err("clr", 1'b0, 1'b0);
        chk("clr s_rd_data", s_rd_data, 8'h00);
        chk("clr s_rd_valid", s_rd_valid, 1'b0);
        chk("clr f_rd_valid", f_rd_valid, 1'b0);
        clr = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        tick();
        chk_level("clr idle", 0);
        chk_err("clr idle", 1'b0, 1'b0);

        // Asynchronous reset in the middle of a burst
        wr_en = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            wr_data = 8'(k);
            tick();
        end
        rd_en = 1'b1;
        wr_data = 8'h04;
        tick();
        chk("burst s_rd_data", s_rd_data, 8'h01);
        chk_level("burst", 3);
        #3;
        sys_rst = 1'b1;
        #1;
        chk_level("async rst", 0);
        chk_err("async rst", 1'b0, 1'b0);
        chk("async rst s_rd_data", s_rd_data, 8'h00);
        chk("async rst s_rd_valid", s_rd_valid, 1'b0);
        chk("async rst f_rd_valid", f_rd_valid, 1'b0);
        wr_en = 1'b0;
        rd_en = 1'b0;
        tick();
        sys_rst = 1'b0;
        wr_en = 1'b1;
        wr_data = 8'h09;
        tick();
        chk_level("post rst", 1);
        chk("post rst f_rd_data", f_rd_data, 8'h09);
        chk("post rst f_rd_valid", f_rd_valid, 1'b1);
        wr_en = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO: the next generation of the team's FIFO IP demo block. Configurable data width and depth, programmable almost-full/almost-empty thresholds, standard or first-word-fall-through (FWFT) read mode, occupancy count, and sticky-free overflow/underflow error pulses. Sits between a producer and a consumer in the same `sys_clk` domain and replaces the fixed 8-bit × 256 FIFO instance in the demo top.

## Interface
Parameters:
- `DATA_W`, 8, data width in bits (≥1)
- `ADDR_W`, 8, address width; depth `DEPTH = 2**ADDR_W`
- `FWFT`, 0, 0 = standard read (registered, 1-cycle latency); 1 = first-word-fall-through
- `AFULL_TH`, `DEPTH-4`, `almost_full` asserts when count ≥ this value
- `AEMPTY_TH`, 4, `almost_empty` asserts when count ≤ this value
- Legal range: 1 ≤ `AEMPTY_TH` < `AFULL_TH` ≤ `DEPTH-1`

Ports:
- Clock and reset: one clock, `sys_clk`; reset is asynchronous and active-high, named `sys_rst`. The polarity and synchronicity of `sys_rst` are fixed.
- `sys_clk`  in  1  clock; all logic is rising-edge
- `sys_rst`  in  1  asynchronous, active-high reset
- `clr`  in  1  synchronous flush; highest priority after reset
- `wr_en`  in  1  write request
- `wr_data`  in  `DATA_W`  write data
- `rd_en`  in  1  read request (in FWFT mode, this is a pop)
- `rd_data`  out  `DATA_W`  read data
- `rd_valid`  out  1  `rd_data` is valid
- `full`  out  1  count == `DEPTH`
- `empty`  out  1  count == 0
- `almost_full`  out  1  count ≥ `AFULL_TH`
- `almost_empty`  out  1  count ≤ `AEMPTY_TH`
- `count`  out  `ADDR_W+1`  number of stored words, 0..`DEPTH`
- `overflow`  out  1  one-cycle pulse for a rejected write
- `underflow`  out  1  one-cycle pulse for a rejected read

## Operation
**Storage and pointers**
- Storage is a `DEPTH`-entry register array. The array itself is not reset.
- `wr_ptr` and `rd_ptr` are `ADDR_W` bits wide. Each wraps from `DEPTH-1` to 0 naturally.

**Accept rules** (evaluated on the same edge)
- A write is accepted iff `wr_en && !full`. An accepted write stores `mem[wr_ptr] <= wr_data` and increments `wr_ptr`.
- A read is accepted iff `rd_en && !empty`. An accepted read increments `rd_ptr`.
- Count update:
  - Write only: +1
  - Read only: −1
  - Both accepted: unchanged
- Full with `wr_en && rd_en`: the read is accepted and the write is rejected. `overflow` pulses and count becomes `DEPTH-1`.
- Empty with `wr_en && rd_en`: the write is accepted and the read is rejected. `underflow` pulses and count becomes 1.
- `overflow` / `underflow` are registered and high for exactly the cycle after the rejected request.

**Flags**
- All flags are combinational decodes of the registered `count`. They are therefore valid from the edge that updates `count`.

**Read modes**
- Standard mode (`FWFT=0`):
  - An accepted read loads `rd_data <= mem[rd_ptr]`.
  - `rd_valid` pulses high in the following cycle.
  - `rd_data` holds its value when no read is accepted.
- FWFT mode (`FWFT=1`):
  - `rd_data = mem[rd_ptr]`, combinational.
  - `rd_valid = !empty`.
  - `rd_en` consumes the displayed word.

**Flush (`clr`)**
- Pointers, `count`, `overflow`, `underflow` and `rd_data` (standard mode) go to 0.
- Any `wr_en` / `rd_en` in the same cycle is ignored and raises no error pulse.

**Reset values**
- `count=0`, `empty=1`, `almost_empty=1`, `full=0`, `almost_full=0`, `overflow=0`, `underflow=0`, `rd_valid=0`.
- `rd_data=0` in standard mode. In FWFT mode `rd_data` is don't-care while empty.

## Timing
- Write to visibility:
  - Write accepted at edge N → `count`/`empty` update at N.
  - FWFT: `rd_data` and `rd_valid` valid from N.
  - Standard: first `rd_en` accepted at edge N+1 gives data at edge N+2.
- Standard read latency: 1 cycle from the accepting edge to `rd_data` / `rd_valid`.
- Back-to-back throughput: one write and one read per cycle, sustained at any fill level 1..`DEPTH-1`.
- Reset mid-operation: outputs go to their reset values immediately (asynchronous). Stored data is lost logically because the pointers are zeroed.
- Deassertion of `sys_rst` is synchronised externally. The first write accepted is the one at the first edge with `sys_rst` low.

## Test plan
All scenarios use `DATA_W=8`, `ADDR_W=4` (DEPTH 16), `AFULL_TH=12`, `AEMPTY_TH=3`; run in both `FWFT=0` and `FWFT=1`.
- Fill and drain: write 0x00..0x0F on 16 consecutive cycles → `full=1` and `count=16`, with `almost_full` rising when `count` reaches 12. Then read 16 words → data returns 0x00..0x0F in order, `empty=1`, and `almost_empty` rises when `count` reaches 3.
- Overflow: at `full`, `wr_en=1` with 0xAA → `overflow` is high one cycle, `count` stays 16, and 0xAA is never read back. Simultaneous `wr_en`+`rd_en` at full → `count=15` and `overflow` pulses.
- Underflow: when empty, `rd_en=1` → `underflow` is high one cycle and `count` stays 0. Simultaneous `wr_en`+`rd_en` when empty → `count=1` and `underflow` pulses.
- Wrap-around: for 40 cycles, write and read every cycle with 4 words resident → the output sequence is exactly the input sequence, `count` stays 4, and there are no error pulses.
- Latency: standard mode, read accepted at edge N → `rd_valid` and data are present at edge N+1. FWFT mode, a single write of 0x5C into an empty FIFO → `rd_data=0x5C` and `rd_valid=1` from the same edge.
- Flush and reset: with 9 words stored, pulse `clr` together with `wr_en` → `count=0`, `empty=1`, no error pulse. Next, assert `sys_rst` asynchronously mid-burst → all outputs take their reset values before the next edge.
